// File: rtl/tx_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tx_ctrl_pkg
// Description : Shared constants for the framed PISO transmit controller:
//               FSM state encoding, serial line levels and a counter-width
//               helper.
// Revision    : 1.0 - initial release
// ============================================================================
package tx_ctrl_pkg;

    // FSM state encoding
    localparam logic [1:0] c_ST_IDLE  = 2'b00;
    localparam logic [1:0] c_ST_START = 2'b01;
    localparam logic [1:0] c_ST_DATA  = 2'b10;
    localparam logic [1:0] c_ST_STOP  = 2'b11;

    // Serial line levels
    localparam logic c_LINE_IDLE = 1'b1;
    localparam logic c_START_BIT = 1'b0;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/piso_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : piso_shift_reg
// Description : Parallel-in / serial-out shift register. Loads a word on
//               i_load, shifts right (zero fill) on i_shift; the serial output
//               is bit 0. Load has priority over shift.
// Ports       : clk     - clock, rising edge
//               rst     - asynchronous active-high reset (clears register)
//               i_load  - load i_din
//               i_shift - shift right by one, MSB filled with 0
//               i_din   - parallel word [WIDTH-1:0]
//               o_ser   - serial output (bit 0)
// Revision    : 1.0 - initial release
// ============================================================================
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_din,
    output logic             o_ser
);

    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shifted;

    generate
        if (WIDTH == 1) begin : g_single
            assign w_shifted = 1'b0;
        end else begin : g_multi
            assign w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg <= '0;
        end else if (i_load) begin
            r_shreg <= i_din;
        end else if (i_shift) begin
            r_shreg <= w_shifted;
        end
    end

    assign o_ser = r_shreg[0];

endmodule

`default_nettype wire

// File: rtl/piso_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : piso_tx_ctrl
// Description : Framed serial transmit controller. Accepts a WIDTH-bit word
//               via valid/ready, then sends start bit (0), data LSB-first and
//               stop bit (1), each bit held for BAUD_DIV clocks.
// Ports       : clk       - clock, rising edge
//               rst       - asynchronous active-high reset
//               din       - parallel word, sampled on the acceptance edge
//               din_valid - producer has a word
//               din_ready - controller can accept (IDLE and rst low)
//               sout      - registered serial line, idles high
//               busy      - frame in progress
//               done      - one-cycle pulse in the first IDLE cycle after STOP
// Revision    : 1.0 - initial release
// ============================================================================
module piso_tx_ctrl
    import tx_ctrl_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int BAUD_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int c_BAUD_W = clog2_min1(BAUD_DIV);
    localparam int c_BIT_W  = clog2_min1(WIDTH);

    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(BAUD_DIV - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(WIDTH - 1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_ONE  = c_BAUD_W'(1);
    localparam logic [c_BIT_W-1:0]  c_BIT_ONE   = c_BIT_W'(1);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_BAUD_W-1:0] r_baud_cnt;
    logic [c_BIT_W-1:0]  r_bit_cnt;

    logic r_sout;
    logic r_busy;
    logic r_done;
    logic w_sout_nxt;
    logic w_busy_nxt;
    logic w_done_nxt;

    logic w_accept;
    logic w_baud_end;
    logic w_bit_end;
    logic w_shift;
    logic w_ser;

    assign din_ready  = (r_state == c_ST_IDLE) && !rst;
    assign w_accept   = din_valid && din_ready;
    assign w_baud_end = (r_baud_cnt == c_BAUD_LAST);
    assign w_bit_end  = (r_bit_cnt == c_BIT_LAST);

    // The shift register advances on the same edge that copies its bit 0
    // into the registered sout: once when leaving START (exposes data bit 0)
    // and at every data-bit boundary except the last. Because sout is a flop,
    // the bit on the line always equals the register's bit 0 of the previous
    // cycle.
    assign w_shift = ((r_state == c_ST_START) && w_baud_end) ||
                     ((r_state == c_ST_DATA) && w_baud_end && !w_bit_end);

    piso_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_accept),
        .i_shift (w_shift),
        .i_din   (din),
        .o_ser   (w_ser)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_accept)                w_state_nxt = c_ST_START;
            c_ST_START: if (w_baud_end)              w_state_nxt = c_ST_DATA;
            c_ST_DATA:  if (w_baud_end && w_bit_end) w_state_nxt = c_ST_STOP;
            c_ST_STOP:  if (w_baud_end)              w_state_nxt = c_ST_IDLE;
            default:                                 w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic (next values of the registered outputs)
    // ------------------------------------------------------------------
    always_comb begin
        w_busy_nxt = (w_state_nxt != c_ST_IDLE);
        w_done_nxt = (r_state == c_ST_STOP) && w_baud_end;
        w_sout_nxt = c_LINE_IDLE;
        if (w_shift) begin
            w_sout_nxt = w_ser;
        end else begin
            case (w_state_nxt)
                c_ST_START: w_sout_nxt = c_START_BIT;
                c_ST_DATA:  w_sout_nxt = r_sout;       // hold current data bit
                default:    w_sout_nxt = c_LINE_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sout <= c_LINE_IDLE;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_sout <= w_sout_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    assign sout = r_sout;
    assign busy = r_busy;
    assign done = r_done;

    // ------------------------------------------------------------------
    // Baud counter: runs in every non-IDLE state, cleared at each bit
    // boundary and on acceptance so a frame always starts from zero.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_baud_cnt <= '0;
        end else if (w_accept || w_baud_end) begin
            r_baud_cnt <= '0;
        end else if (r_state != c_ST_IDLE) begin
            r_baud_cnt <= r_baud_cnt + c_BAUD_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Bit counter: index of the data bit on the line, advances only at
    // DATA bit boundaries and clears after the last bit.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt <= '0;
        end else if (w_accept) begin
            r_bit_cnt <= '0;
        end else if ((r_state == c_ST_DATA) && w_baud_end) begin
            if (w_bit_end) begin
                r_bit_cnt <= '0;
            end else begin
                r_bit_cnt <= r_bit_cnt + c_BIT_ONE;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_piso_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_tx_ctrl
// Description : Self-checking bench for piso_tx_ctrl. Two instances: A with
//               WIDTH=8/BAUD_DIV=4 and B with WIDTH=4/BAUD_DIV=1. Expected
//               line values come from a frame model {stop, data, start}
//               indexed by (cycle-1)/BAUD_DIV.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_tx_ctrl;

    localparam int c_AW = 8;
    localparam int c_AB = 4;
    localparam int c_BW = 4;
    localparam int c_BB = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst, a_din_valid, a_din_ready, a_sout, a_busy, a_done;
    logic [7:0] a_din;
    logic       b_rst, b_din_valid, b_din_ready, b_sout, b_busy, b_done;
    logic [3:0] b_din;

    int n_vec = 0;
    int n_err = 0;

    piso_tx_ctrl #(.WIDTH(c_AW), .BAUD_DIV(c_AB)) u_dut_a (
        .clk       (clk),
        .rst       (a_rst),
        .din       (a_din),
        .din_valid (a_din_valid),
        .din_ready (a_din_ready),
        .sout      (a_sout),
        .busy      (a_busy),
        .done      (a_done)
    );

    piso_tx_ctrl #(.WIDTH(c_BW), .BAUD_DIV(c_BB)) u_dut_b (
        .clk       (clk),
        .rst       (b_rst),
        .din       (b_din),
        .din_valid (b_din_valid),
        .din_ready (b_din_ready),
        .sout      (b_sout),
        .busy      (b_busy),
        .done      (b_done)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic get_obs(input int sel, output logic s, output logic b,
                           output logic d, output logic r);
        if (sel == 0) begin
            s = a_sout; b = a_busy; d = a_done; r = a_din_ready;
        end else begin
            s = b_sout; b = b_busy; d = b_done; r = b_din_ready;
        end
    endtask

    task automatic drive(input int sel, input logic [7:0] w, input logic v);
        if (sel == 0) begin
            a_din = w; a_din_valid = v;
        end else begin
            b_din = w[3:0]; b_din_valid = v;
        end
    endtask

    task automatic set_rst(input int sel, input logic v);
        if (sel == 0) a_rst = v;
        else          b_rst = v;
    endtask

    // Check all four outputs against fixed values
    task automatic chk_all(input int sel, input string tag, input logic es,
                           input logic eb, input logic ed, input logic er);
        logic s, b, d, r;
        get_obs(sel, s, b, d, r);
        chk($sformatf("%s_%0d_sout", tag, sel), s, es);
        chk($sformatf("%s_%0d_busy", tag, sel), b, eb);
        chk($sformatf("%s_%0d_done", tag, sel), d, ed);
        chk($sformatf("%s_%0d_ready", tag, sel), r, er);
    endtask

    // Called at a negedge with the DUT idle. Offers 'word', then checks every
    // cycle of the frame plus the done cycle. keep: leave din_valid high at
    // the end (caller sends the next word back-to-back). noise: scramble
    // din/din_valid during the frame. abort_at>0: assert rst in that cycle.
    task automatic send(input int sel, input logic [7:0] word, input bit keep,
                        input bit noise, input int abort_at);
        int   w  = (sel == 0) ? c_AW : c_BW;
        int   bd = (sel == 0) ? c_AB : c_BB;
        int   n  = (w + 2) * bd;
        logic [9:0] fr;
        logic s, b, d, r;
        fr = '0;
        for (int j = 0; j < w; j++) fr[j+1] = word[j];
        fr[0]   = 1'b0;
        fr[w+1] = 1'b1;
        drive(sel, word, 1'b1);
        get_obs(sel, s, b, d, r);
        chk($sformatf("pre_ready_%0d", sel), r, 1'b1);
        @(posedge clk);
        #1;
        drive(sel, 8'($urandom), keep);
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge clk);
            get_obs(sel, s, b, d, r);
            chk($sformatf("sout_%0d_c%0d", sel, k), s,
                (k <= n) ? fr[(k-1)/bd] : 1'b1);
            chk($sformatf("busy_%0d_c%0d", sel, k), b, k <= n);
            chk($sformatf("done_%0d_c%0d", sel, k), d, k == n + 1);
            chk($sformatf("ready_%0d_c%0d", sel, k), r, k == n + 1);
            if (k == abort_at) begin
                drive(sel, 8'h00, 1'b0);
                set_rst(sel, 1'b1);
                #1;
                chk_all(sel, "abort", 1'b1, 1'b0, 1'b0, 1'b0);
                return;
            end
            if (k <= n && noise)
                drive(sel, 8'($urandom), 1'($urandom));
            else if (k == n + 1)
                drive(sel, 8'($urandom), keep);
        end
    endtask

    task automatic idle_chk(input int sel, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk_all(sel, $sformatf("idle%0d", i), 1'b1, 1'b0, 1'b0, 1'b1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        a_rst = 1'b0; a_din = '0; a_din_valid = 1'b0;
        b_rst = 1'b0; b_din = '0; b_din_valid = 1'b0;

        // Reset pulsed between edges: outputs respond without a clock edge
        #12;
        a_rst = 1'b1;
        b_rst = 1'b1;
        #1;
        chk_all(0, "rst", 1'b1, 1'b0, 1'b0, 1'b0);
        chk_all(1, "rst", 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        a_rst = 1'b0;
        b_rst = 1'b0;
        @(negedge clk);
        chk_all(0, "post_rst", 1'b1, 1'b0, 1'b0, 1'b1);
        chk_all(1, "post_rst", 1'b1, 1'b0, 1'b0, 1'b1);

        // Basic frame
        send(0, 8'hA5, 1'b0, 1'b0, 0);
        idle_chk(0, 2);

        // Back-to-back: second word accepted in the done cycle
        send(0, 8'h00, 1'b1, 1'b0, 0);
        send(0, 8'hFF, 1'b0, 1'b0, 0);
        idle_chk(0, 1);

        // Mid-frame interference on din/din_valid, no extra frame afterwards
        send(0, 8'h3C, 1'b0, 1'b1, 0);
        idle_chk(0, 3);

        // Mid-frame reset in cycle 20, then a clean frame
        send(0, 8'hA5, 1'b0, 1'b0, 20);
        @(posedge clk);
        @(negedge clk);
        chk_all(0, "rst_hold", 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        a_rst = 1'b0;
        @(negedge clk);
        chk_all(0, "rst_rel", 1'b1, 1'b0, 1'b0, 1'b1);
        send(0, 8'h3C, 1'b0, 1'b0, 0);
        idle_chk(0, 1);

        // Narrow, one clock per bit
        send(1, 8'h09, 1'b0, 1'b0, 0);
        idle_chk(1, 1);

        // Randomized frames on both configurations
        for (int i = 0; i < 6; i++)
            send(0, 8'($urandom), (i < 5) ? 1'($urandom) : 1'b0, 1'($urandom), 0);
        idle_chk(0, 2);
        for (int i = 0; i < 10; i++)
            send(1, 8'($urandom), (i < 9) ? 1'($urandom) : 1'b0, 1'($urandom), 0);
        idle_chk(1, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/piso_tx_ctrl.md
Name: piso_tx_ctrl

Overview:
Framed serial transmit controller that sequences a parallel-in/serial-out shift register built from D flip-flops.
- Accepts a parallel word through a valid/ready handshake.
- Serializes the word LSB-first with one start bit (0) and one stop bit (1).
- Each bit is held for a programmable number of clocks.
- Sits between the lab's register/datapath logic and a single-wire serial output.

Parameters:
WIDTH, 8, data bits per frame (>=1)
BAUD_DIV, 4, clock cycles per serial bit (>=1; 1 = one clock per bit)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
din  input  WIDTH  parallel word, sampled only on the acceptance edge
din_valid  input  1  producer has a word
din_ready  output  1  controller can accept; high only in IDLE and while rst is low
sout  output  1  registered serial line, idles high
busy  output  1  frame in progress (START/DATA/STOP)
done  output  1  one-cycle pulse in the first IDLE cycle after STOP

Behaviour:
- Clocking and reset: single clock domain (clk), asynchronous active-high reset (rst).
- While rst is high: state=IDLE, sout=1, busy=0, done=0, din_ready=0. Baud counter, bit counter and shift register are cleared.
- FSM states and transitions:
  - IDLE: din_ready=1. Acceptance is the rising edge with din_valid && din_ready. On that edge: load din into the shift register, clear counters, go to START.
  - START: sout=0 for BAUD_DIV cycles, then go to DATA.
  - DATA: sout=shreg[0]. At each bit boundary (baud count == BAUD_DIV-1), shift right and increment the bit index. After bit WIDTH-1 completes, go to STOP.
  - STOP: sout=1 for BAUD_DIV cycles. Then go to IDLE with done=1 for exactly one cycle.
- Frame timing: the frame occupies cycles 1..(WIDTH+2)*BAUD_DIV after the acceptance edge.
  - busy=1 in exactly those cycles.
  - done and din_ready are both high in the following cycle.
- Back-to-back: acceptance is allowed in the done cycle. The line then shows exactly one extra idle-high cycle between the stop bit and the next start bit.
- din and din_valid are ignored outside the acceptance edge. Changes to din mid-frame do not affect the frame in progress.
- Counter widths:
  - Baud counter: max(1, clog2(BAUD_DIV)) bits.
  - Bit counter: max(1, clog2(WIDTH)) bits.
  - Neither counter wraps past its terminal value; both are cleared at each boundary.
- Reset mid-frame: abandons the frame immediately without waiting for a clock edge. sout returns to 1 and no done pulse is produced. The first cycle after rst falls is IDLE.
- All outputs except din_ready come from flops. din_ready = (state==IDLE) && !rst.

Decomposition:
- Shared package tx_ctrl_pkg holds:
  - state encoding: IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11
  - LINE_IDLE=1'b1
  - START_BIT=1'b0
- One sub-module, piso_shift_reg, parameterized by WIDTH:
  - asynchronous active-high rst
  - load and shift enables
  - serial output = bit 0
  - shift-right fills with 0
- The controller owns the FSM, the baud counter and the bit counter.

Test Plan:
1. Reset: pulse rst between clock edges -> sout=1, busy=0, done=0, din_ready=0 immediately. After release, din_ready=1 on the next cycle.
2. WIDTH=8, BAUD_DIV=4, din=8'hA5 accepted:
   - cycles 1-4: sout=0
   - cycles 5-36: bits 1,0,1,0,0,1,0,1, 4 cycles each
   - cycles 37-40: sout=1
   - busy=1 in cycles 1-40; done=1 and din_ready=1 only in cycle 41
3. Back-to-back: din_valid held high with 8'h00 then 8'hFF -> second frame accepted in the done cycle (41). Its start bit begins in cycle 42, and sout=1 in cycle 41.
4. Mid-frame interference: during DATA, set din=8'h3C and pulse din_valid -> din_ready stays 0, the transmitted bits stay those of the original word, and no extra frame is sent.
5. Mid-frame reset: assert rst in cycle 20 of an 8'hA5 frame -> sout=1 and busy=0 at once, with no done. After release, 8'h3C transmits as 0,0,0,1,1,1,1,0,0 then stop.
6. WIDTH=4, BAUD_DIV=1, din=4'b1001 -> sout=0,1,0,0,1,1 in cycles 1-6, done in cycle 7.
